fir_l3_serializer: RTL

FIR_L3_SERIALIZER -- requirements
Module: fir_l3_serializer

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_quantize.sv | 52 +++++
 rtl/fir_l3_serializer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared defaults for the FIR output serializer: lane count, widths,
// quantisation shift and the saturation limits of the default output width.
package fir_pkg;

  localparam int DEF_LANES          = 3;
  localparam int DEF_DATA_IN_WIDTH  = 64;
  localparam int DEF_DATA_OUT_WIDTH = 16;
  localparam int DEF_SHIFT          = 23;

  // Clip limits for a DEF_DATA_OUT_WIDTH-bit signed sample.
  localparam logic signed [DEF_DATA_OUT_WIDTH-1:0] SAT_MAX =
    {1'b0, {(DEF_DATA_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_DATA_OUT_WIDTH-1:0] SAT_MIN =
    {1'b1, {(DEF_DATA_OUT_WIDTH-1){1'b0}}};

  // Width of a counter that indexes 0..lanes-1 (at least one bit).
  function automatic int lane_cnt_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/fir_quantize.sv
// Combinational quantiser: round-half-up right shift by SHIFT, computed one
// bit wider than the input so the rounding add never wraps.
// Saturation is compiled in only when FIR_SERIALIZER_SAT_EN is defined;
// otherwise the result is the two's-complement low bits and sat_o is 0.
module fir_quantize
  import fir_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
  parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
  parameter int SHIFT          = DEF_SHIFT
) (
  input  logic [DATA_IN_WIDTH-1:0]  din_i,
  output logic [DATA_OUT_WIDTH-1:0] dout_o,
  output logic                      sat_o
);

  localparam int SW = DATA_IN_WIDTH + 1;
  localparam logic [SW-1:0] RND = SW'(1) << (SHIFT - 1);

  logic signed [SW-1:0] sum_w;
  logic signed [SW-1:0] r_w;

  assign sum_w = $signed({din_i[DATA_IN_WIDTH-1], din_i}) + $signed(RND);
  assign r_w   = sum_w >>> SHIFT;

`ifdef FIR_SERIALIZER_SAT_EN
  // Output range limits expressed at the wide rounding width.
  localparam logic signed [SW-1:0] R_MAX =
    {{(SW-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] R_MIN = ~R_MAX;

  // Clip the rounded value into the signed output range and flag it.
  always_comb begin
    dout_o = r_w[DATA_OUT_WIDTH-1:0];
    sat_o  = 1'b0;
    if (r_w > R_MAX) begin
      dout_o = R_MAX[DATA_OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end else if (r_w < R_MIN) begin
      dout_o = R_MIN[DATA_OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end
  end
`else
  // Upper bits are intentionally dropped: the sample wraps.
  logic unused_hi;
  assign unused_hi = ^r_w[SW-1:DATA_OUT_WIDTH];
  assign dout_o    = r_w[DATA_OUT_WIDTH-1:0];
  assign sat_o     = 1'b0;
`endif

endmodule

// File: rtl/fir_l3_serializer.sv
// Parallel-to-serial converter for a multi-lane FIR: holds one accepted
// LANES-wide word and emits one quantised sample per cycle, lane 0 first,
// with a ready/valid handshake on both sides. A new word is accepted in the
// same cycle the last lane is emitted, so back-to-back words stream without
// bubbles. Optional saturation: define FIR_SERIALIZER_SAT_EN.
module fir_l3_serializer
  import fir_pkg::*;
#(
  parameter int LANES          = DEF_LANES,
  parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
  parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
  parameter int SHIFT          = DEF_SHIFT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*DATA_IN_WIDTH-1:0]    in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_OUT_WIDTH-1:0]         out_data,
  output logic                              sat_flag
);

  localparam int LCW = lane_cnt_width(LANES);
  localparam logic [LCW-1:0] LAST_LANE = LCW'(LANES - 1);

  logic [LANES*DATA_IN_WIDTH-1:0] hold_q, hold_d;
  logic                           hold_valid_q, hold_valid_d;
  logic [LCW-1:0]                 lane_cnt_q, lane_cnt_d;
  logic                           out_valid_q, out_valid_d;
  logic [DATA_OUT_WIDTH-1:0]      out_data_q, out_data_d;
  logic                           sat_q, sat_d;

  logic                           advance;
  logic                           last_lane;
  logic                           accept;
  logic [DATA_IN_WIDTH-1:0]       lane_w [LANES];
  logic [DATA_OUT_WIDTH-1:0]      q_data;
  logic                           q_sat;

  // Split the holding register into per-lane words for the lane mux.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_w[gi] = hold_q[gi*DATA_IN_WIDTH +: DATA_IN_WIDTH];
    end
  endgenerate

  // The output register may load when empty or being consumed this cycle.
  assign advance   = !out_valid_q || out_ready;
  assign last_lane = (lane_cnt_q == LAST_LANE);
  assign in_ready  = !hold_valid_q || (last_lane && advance);
  assign accept    = in_valid && in_ready;

  fir_quantize #(
    .DATA_IN_WIDTH (DATA_IN_WIDTH),
    .DATA_OUT_WIDTH(DATA_OUT_WIDTH),
    .SHIFT         (SHIFT)
  ) u_quantize (
    .din_i (lane_w[lane_cnt_q]),
    .dout_o(q_data),
    .sat_o (q_sat)
  );

  // Next-state: emit the selected lane, step the lane counter, load new words.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    lane_cnt_d   = lane_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    sat_d        = sat_q;

    if (advance) begin
      if (hold_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = q_data;
        sat_d       = q_sat;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // A new word always restarts at lane 0; this also covers the
    // last-lane/accept overlap that keeps the stream gap-free.
    if (accept) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
      lane_cnt_d   = '0;
    end else if (advance && hold_valid_q) begin
      if (last_lane) begin
        hold_valid_d = 1'b0;
        lane_cnt_d   = '0;
      end else begin
        lane_cnt_d = lane_cnt_q + LCW'(1);
      end
    end
  end

  // Control and output registers; reset discards any partially sent word.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      lane_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      sat_q        <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      lane_cnt_q   <= lane_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      sat_q        <= sat_d;
    end
  end

  // Lane data needs no reset; it is only read while hold_valid_q is set.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;

endmodule
